// File: rtl/la_dump_ctrl.sv
// la_dump_ctrl: streams one captured channel out of the circular capture RAM to
// uart_tx, oldest sample first, one byte per trmt/tx_done handshake.
// Optional build macro: DUMP_CHKSUM_EN appends an 8-bit modulo-256 sum byte.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for dump_start; invalid channel answers with nak
//   RD    | ram_en asserted for one cycle at the current address
//   WAIT  | read data arrives; captured into tx_data, trmt issued next
//   TX    | waiting for tx_done (ignored in first cycle, it is still stale)
//   CHK   | (DUMP_CHKSUM_EN only) load checksum into tx_data, trmt next
//   DONE  | one-cycle dump_done, then back to IDLE
module la_dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump_start,
  input  logic [2:0]      dump_chan,
  input  logic [LOG2-1:0] wrt_ptr,
  output logic [LOG2-1:0] ram_addr,
  output logic            ram_en,
  output logic [2:0]      ram_ch,
  input  logic [7:0]      ram_rdata,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  output logic            busy,
  output logic            dump_done,
  output logic            nak
);

`ifdef DUMP_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_TX, S_CHK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_TX, S_DONE} state_t;
`endif

  state_t          state, nxt_state;
  logic [LOG2-1:0] addr;
  logic [LOG2-1:0] cnt;
  logic            chan_ok;
  logic            last_byte;
  logic            byte_done;
`ifdef DUMP_CHKSUM_EN
  logic [7:0]      sum;
  logic            chk_phase;
`endif

  assign chan_ok   = (dump_chan >= 3'd1) && (dump_chan <= 3'd5);
  assign last_byte = (cnt == LOG2'(ENTRIES - 1));
  // trmt is high exactly in the first TX cycle, when tx_done is still the
  // previous byte's flag and must not count.
  assign byte_done = (state == S_TX) && !trmt && tx_done;
  assign ram_addr  = addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic and outputs decoded from the state register.
  always_comb begin
    nxt_state = state;
    ram_en    = 1'b0;
    dump_done = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (dump_start && chan_ok) nxt_state = S_RD;
      S_RD: begin
        ram_en    = 1'b1;
        nxt_state = S_WAIT;
      end
      S_WAIT: nxt_state = S_TX;
      S_TX: begin
        if (byte_done) begin
`ifdef DUMP_CHKSUM_EN
          if (chk_phase)      nxt_state = S_DONE;
          else if (last_byte) nxt_state = S_CHK;
          else                nxt_state = S_RD;
`else
          if (last_byte) nxt_state = S_DONE;
          else           nxt_state = S_RD;
`endif
        end
      end
`ifdef DUMP_CHKSUM_EN
      S_CHK: nxt_state = S_TX;
`endif
      S_DONE: begin
        dump_done = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Datapath: channel/address/count registers, tx byte, trmt and nak pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      cnt     <= '0;
      ram_ch  <= '0;
      tx_data <= '0;
      trmt    <= 1'b0;
      nak     <= 1'b0;
`ifdef DUMP_CHKSUM_EN
      sum       <= '0;
      chk_phase <= 1'b0;
`endif
    end else begin
      nak <= (state == S_IDLE) && dump_start && !chan_ok;
`ifdef DUMP_CHKSUM_EN
      trmt <= (state == S_WAIT) || (state == S_CHK);
`else
      trmt <= (state == S_WAIT);
`endif
      case (state)
        S_IDLE: begin
          if (dump_start && chan_ok) begin
            ram_ch <= dump_chan;
            // An out-of-range write pointer restarts the walk at location 0.
            addr   <= ({1'b0, wrt_ptr} >= (LOG2+1)'(ENTRIES)) ? '0 : wrt_ptr;
            cnt    <= '0;
`ifdef DUMP_CHKSUM_EN
            sum       <= '0;
            chk_phase <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          tx_data <= ram_rdata;
`ifdef DUMP_CHKSUM_EN
          sum <= sum + ram_rdata;
`endif
        end
        S_TX: begin
          if (byte_done && !last_byte) begin
            cnt  <= cnt + 1'b1;
            addr <= (addr == LOG2'(ENTRIES - 1)) ? '0 : addr + 1'b1;
          end
        end
`ifdef DUMP_CHKSUM_EN
        S_CHK: begin
          tx_data   <= sum;
          chk_phase <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_dump_ctrl.sv
// Scoreboard bench for la_dump_ctrl: the bench predicts the byte and address
// stream of every accepted dump from its own RAM image; a negedge monitor
// pops and compares whenever the DUT shows ram_en, trmt, nak or dump_done.
module tb_la_dump_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            dump_start = 1'b0;
  logic [2:0]      dump_chan = '0;
  logic [LOG2-1:0] wrt_ptr = '0;
  logic [LOG2-1:0] ram_addr;
  logic            ram_en;
  logic [2:0]      ram_ch;
  logic [7:0]      ram_rdata = '0;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            tx_done = 1'b0;
  logic            busy;
  logic            dump_done;
  logic            nak;

  la_dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .dump_start(dump_start), .dump_chan(dump_chan),
    .wrt_ptr(wrt_ptr), .ram_addr(ram_addr), .ram_en(ram_en), .ram_ch(ram_ch),
    .ram_rdata(ram_rdata), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .busy(busy), .dump_done(dump_done), .nak(nak)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8][ENTRIES];
  int  exp_byte[$];
  int  exp_addr[$];
  int  exp_ch = 0;
  int  exp_n = 0;
  int  nak_pending = 0;
  int  trmt_cnt = 0;
  bit  active = 1'b0;
  int  dmin = 2;
  int  dmax = 6;
  int  tx_cnt = 0;

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic void fail(string name);
    errors++;
    $display("FAIL %s", name);
  endfunction

  // Capture RAM: data appears one cycle after ram_en.
  always @(posedge clk)
    if (ram_en) ram_rdata <= (ram_addr < ENTRIES) ? mem[ram_ch][ram_addr] : 8'hEE;

  // UART: trmt clears tx_done, which rises again a random delay later.
  always @(posedge clk) begin
    if (trmt) begin
      tx_done <= 1'b0;
      tx_cnt  <= $urandom_range(dmax, dmin);
    end else if (tx_cnt > 0) begin
      if (tx_cnt == 1) tx_done <= 1'b1;
      tx_cnt <= tx_cnt - 1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) begin
        if (exp_addr.size() == 0) fail("unexpected_ram_en");
        else chk("ram_addr", int'(ram_addr), exp_addr.pop_front());
        chk("ram_ch", int'(ram_ch), exp_ch);
        chk("ram_en_trmt_overlap", int'(trmt), 0);
      end
      if (trmt) begin
        trmt_cnt++;
        if (exp_byte.size() == 0) fail("unexpected_trmt");
        else chk("tx_data", int'(tx_data), exp_byte.pop_front());
      end
      if (nak) begin
        chk("nak_expected", int'(nak_pending > 0), 1);
        if (nak_pending > 0) nak_pending--;
      end
      if (dump_done) begin
        chk("done_while_active", int'(active), 1);
        chk("done_bytes_left", exp_byte.size(), 0);
        chk("done_trmt_count", trmt_cnt, exp_n);
        chk("done_busy", int'(busy), 1);
        active = 1'b0;
      end
    end
  end

  task automatic start(input int ch, input int ptr);
    bit acc = 1'b0;
    bit nk = 1'b0;
    int s, sum;
    @(negedge clk);
    dump_start = 1'b1;
    dump_chan  = 3'(ch);
    wrt_ptr    = LOG2'(ptr);
    if (!active) begin
      if (ch >= 1 && ch <= 5) begin
        acc = 1'b1;
        s = (ptr >= ENTRIES) ? 0 : ptr;
        sum = 0;
        exp_byte.delete();
        exp_addr.delete();
        for (int i = 0; i < ENTRIES; i++) begin
          exp_addr.push_back((s + i) % ENTRIES);
          exp_byte.push_back(int'(mem[ch][(s + i) % ENTRIES]));
          sum += int'(mem[ch][(s + i) % ENTRIES]);
        end
        exp_n = ENTRIES;
`ifdef DUMP_CHKSUM_EN
        exp_byte.push_back(sum % 256);
        exp_n = ENTRIES + 1;
`endif
        exp_ch   = ch;
        trmt_cnt = 0;
        active   = 1'b1;
      end else begin
        nk = 1'b1;
        nak_pending++;
      end
    end
    @(negedge clk);
    dump_start = 1'b0;
    if (acc) begin
      chk("start_ram_en_latency", int'(ram_en), 1);
      chk("start_busy", int'(busy), 1);
    end
    if (nk) begin
      chk("nak_latency", int'(nak), 1);
      chk("nak_ram_en", int'(ram_en), 0);
      chk("nak_busy", int'(busy), 0);
      @(negedge clk);
      chk("nak_one_cycle", int'(nak), 0);
      chk("nak_trmt", int'(trmt), 0);
    end
  endtask

  task automatic wait_done();
    int lim = ENTRIES * (dmax + 8) + 200;
    int i = 0;
    while (active && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (active) begin
      fail("dump_done_timeout");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      active = 1'b0;
      exp_byte.delete();
      exp_addr.delete();
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_single_pulse", int'(dump_done), 0);
  endtask

  task automatic wait_trmts(input int n);
    int i = 0;
    while (trmt_cnt < n && i < 100 * (dmax + 8)) begin
      @(negedge clk);
      i++;
    end
    chk("reached_byte_count", int'(trmt_cnt >= n), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_en"}, int'(ram_en), 0);
    chk({tag, "_ram_ch"}, int'(ram_ch), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_trmt"}, int'(trmt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_dump_done"}, int'(dump_done), 0);
    chk({tag, "_nak"}, int'(nak), 0);
  endtask

  initial begin
    for (int c = 0; c < 8; c++)
      for (int a = 0; a < ENTRIES; a++)
        mem[c][a] = (c == 1 || c == 3) ? 8'(a) : 8'($urandom);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain dump, fixed UART latency of 10.
    dmin = 10; dmax = 10;
    start(1, 0);
    wait_done();

    // Wrap-around from a pointer near the top.
    dmin = 2; dmax = 6;
    start(3, 380);
    wait_done();

    // Invalid channels.
    start(0, 5);
    start(6, 5);
    start(7, 5);

    // Request while busy is ignored.
    start(2, $urandom_range(ENTRIES - 1, 0));
    wait_trmts(20);
    start(5, 0);
    wait_done();

    // Reset mid-dump.
    start(4, $urandom_range(ENTRIES - 1, 0));
    wait_trmts(10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    exp_byte.delete();
    exp_addr.delete();
    active = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    start(1, 0);
    wait_done();

    // Randomised dumps, including out-of-range write pointers.
    for (int k = 0; k < 2; k++) begin
      start($urandom_range(5, 1), $urandom_range(511, 0));
      wait_done();
    end
    start($urandom_range(7, 6), $urandom_range(511, 0));

`ifdef DUMP_CHKSUM_EN
    for (int a = 0; a < ENTRIES; a++) mem[5][a] = 8'h01;
    start(5, 0);
    wait_done();
`endif

    repeat (5) @(negedge clk);
    chk("nak_all_seen", nak_pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/la_dump_ctrl.md
Name: la_dump_ctrl

Overview:
Sequencer that dumps one captured channel from the logic-analyzer capture RAM to the host over UART once a capture completes. It reads the circular buffer starting at the oldest sample, walks all ENTRIES locations with wrap-around, and hands each byte to the UART transmitter through a trmt/tx_done handshake. It sits between the command processor (which issues dump_start and a channel number), the capture RAM read port with its channel mux, and uart_tx.

Parameters:
ENTRIES, 384, number of sample locations per channel (12288 on hardware)
LOG2, 9, address width; 2**LOG2 >= ENTRIES

Ports:
clk  in  1  system clock (100MHz)
rst  in  1  synchronous active-high reset
dump_start  in  1  one-cycle request from the command processor
dump_chan  in  3  channel to dump; 1..5 valid; 0, 6 and 7 invalid
wrt_ptr  in  LOG2  capture write pointer, which is the address of the oldest sample
ram_addr  out  LOG2  capture RAM read address
ram_en  out  1  capture RAM read enable; read data is valid 1 cycle later
ram_ch  out  3  select for the external channel read mux (latched dump_chan)
ram_rdata  in  8  muxed capture RAM read data
tx_data  out  8  byte to the UART transmitter
trmt  out  1  one-cycle transmit strobe
tx_done  in  1  UART byte-complete flag (level; cleared by the transmitter on trmt)
busy  out  1  high from acceptance of a dump until its dump_done
dump_done  out  1  one-cycle pulse when the dump finishes
nak  out  1  one-cycle pulse when a request has an invalid channel

Behaviour:
- Reset: state IDLE; all of the following are 0: ram_addr, ram_en, ram_ch, tx_data, trmt, busy, dump_done, nak, and the byte counter. rst asserted mid-dump returns to IDLE on that edge; the transfer is dropped with no dump_done.
- FSM states: IDLE, RD, WAIT, TX, DONE.
- IDLE:
  - dump_start with dump_chan in 1..5: latch ram_ch <= dump_chan, addr <= wrt_ptr, cnt <= 0, busy <= 1, go to RD.
  - dump_start with an invalid channel: nak = 1 on the next cycle; stay in IDLE; no RAM access.
- RD: ram_en = 1 and ram_addr = addr for exactly 1 cycle, then go to WAIT.
- WAIT: register tx_data <= ram_rdata, trmt = 1 for 1 cycle, go to TX.
- TX:
  - tx_done is ignored in the first TX cycle. From the second cycle onward the first high tx_done completes the byte.
  - On completion with cnt == ENTRIES-1: go to DONE.
  - On completion otherwise: cnt <= cnt+1, addr <= (addr == ENTRIES-1) ? 0 : addr+1, go to RD.
- DONE: dump_done = 1 for 1 cycle, busy <= 0, go to IDLE.
- Address wrap is at ENTRIES-1, not at 2**LOG2-1. If wrt_ptr >= ENTRIES, it is treated as 0.
- dump_start while busy is ignored: no nak, and no change to the channel or the count.
- Latency:
  - dump_start to the first ram_en: 1 cycle.
  - ram_en to trmt: 2 cycles.
  - tx_done to the next ram_en: 1 cycle.
- Each dump sends exactly ENTRIES bytes, ordered from oldest to newest.
- All outputs are registered or decoded directly from the state register; there are no combinational input-to-output paths.

Optional Feature:
Macro DUMP_CHKSUM_EN.
- Defined: after the ENTRIES-th byte completes, the FSM enters CHK. In CHK it sends one extra byte, the 8-bit sum modulo 256 of all data bytes sent, using the same trmt/tx_done handshake. The sum register clears when the dump starts. dump_done follows completion of the checksum byte. Total = ENTRIES+1 bytes.
- Not defined: no CHK state and no sum register; behaviour is exactly as above.

Test Plan:
1. ENTRIES=384, wrt_ptr=0, dump_chan=1, RAM model returns addr[7:0], and the UART model raises tx_done 10 cycles after trmt -> 384 bytes 0x00..0xFF then 0x00..0x7F; ram_ch=1; one dump_done pulse; busy falls with it.
2. wrt_ptr=380, dump_chan=3 -> ram_addr sequence 380,381,382,383,0,1,...,379; first byte 0x7C, last byte 0x7B; ram_addr never reaches 384.
3. dump_start with dump_chan=0, then 6, then 7 -> one nak pulse each on the next cycle; ram_en, trmt and busy stay 0.
4. dump_start pulsed with dump_chan=5 during byte 20 of a dump with dump_chan=2 -> no effect; ram_ch stays 2; exactly 384 trmt pulses.
5. rst for 1 cycle after byte 10 -> next cycle all outputs 0 and state IDLE; no dump_done; a new dump_start with wrt_ptr=0 sends 384 bytes starting at address 0.
6. DUMP_CHKSUM_EN defined, RAM returns 0x01 everywhere -> 385 bytes; the final byte is 0x80; dump_done comes after the 385th tx_done.
